// File: rtl/f2x_arbiter.sv
// f2x_arbiter: two-requester round-robin front end that converts
// IEEE-754 single angles to unsigned fixed point for the CORDIC core.
module f2x_arbiter #(
   parameter int INT_BITS  = 1,
   parameter int FRAC_BITS = 22,
   parameter int WIDTH     = 1 + INT_BITS + FRAC_BITS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   input  logic [63:0]      req_float,
   output logic [1:0]       req_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_fixed,
   output logic             out_id,
   output logic             out_ovf
);

   logic             s1_v_q, s1_v_d;
   logic [31:0]      s1_float_q, s1_float_d;
   logic             s1_id_q, s1_id_d;
   logic             s2_v_q, s2_v_d;
   logic [WIDTH-1:0] s2_fixed_q, s2_fixed_d;
   logic             s2_id_q, s2_id_d;
   logic             s2_ovf_q, s2_ovf_d;
   logic             last_q, last_d;

   logic             adv1, adv2;
   logic [1:0]       gnt;
   logic             accept;
   logic             acc_id;

   logic [7:0]       cv_exp;
   logic [7:0]       cv_shamt;
   logic [23:0]      cv_mant;
   logic [WIDTH+23:0] cv_wide;
   logic [WIDTH-1:0] cv_fixed;
   logic             cv_ovf;

   assign adv2 = !s2_v_q | out_ready;
   assign adv1 = !s1_v_q | adv2;

   // Round-robin grant: on contention the requester not granted last wins.
   always_comb begin
      gnt = 2'b00;
      case (req_valid)
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   assign req_ready = reset ? 2'b00 : (gnt & {2{adv1}});
   assign accept    = |req_ready;
   assign acc_id    = req_ready[1];

   assign cv_exp   = s1_float_q[30:23];
   assign cv_mant  = {1'b1, s1_float_q[22:0]};
   assign cv_shamt = 8'd128 - cv_exp;

   // Float-to-fixed conversion of the S1 operand (sign ignored).
   always_comb begin
      cv_fixed = '0;
      cv_ovf   = 1'b0;
      cv_wide  = '0;
      if (s1_float_q[30:0] == 31'd0) begin
         cv_fixed = '0;
      end else if (cv_exp[7]) begin
         cv_fixed = {1'b0, {(WIDTH-1){1'b1}}};
         cv_ovf   = 1'b1;
      end else if (cv_shamt < 8'd24) begin
         cv_wide  = {{WIDTH{1'b0}}, (cv_mant >> cv_shamt[4:0])};
         cv_fixed = cv_wide[WIDTH-1:0];
         cv_fixed[WIDTH-1] = 1'b0;
      end
   end

   // Next-state for both pipeline stages and the round-robin pointer.
   always_comb begin
      s1_v_d     = s1_v_q;
      s1_float_d = s1_float_q;
      s1_id_d    = s1_id_q;
      s2_v_d     = s2_v_q;
      s2_fixed_d = s2_fixed_q;
      s2_id_d    = s2_id_q;
      s2_ovf_d   = s2_ovf_q;
      last_d     = last_q;
      if (adv1) begin
         s1_v_d = accept;
         if (accept) begin
            s1_float_d = acc_id ? req_float[63:32] : req_float[31:0];
            s1_id_d    = acc_id;
            last_d     = acc_id;
         end
      end
      if (adv2) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_fixed_d = cv_fixed;
            s2_id_d    = s1_id_q;
            s2_ovf_d   = cv_ovf;
         end
      end
   end

   // Pipeline registers; reset discards anything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v_q     <= 1'b0;
         s1_float_q <= '0;
         s1_id_q    <= 1'b0;
         s2_v_q     <= 1'b0;
         s2_fixed_q <= '0;
         s2_id_q    <= 1'b0;
         s2_ovf_q   <= 1'b0;
         last_q     <= 1'b1;
      end else begin
         s1_v_q     <= s1_v_d;
         s1_float_q <= s1_float_d;
         s1_id_q    <= s1_id_d;
         s2_v_q     <= s2_v_d;
         s2_fixed_q <= s2_fixed_d;
         s2_id_q    <= s2_id_d;
         s2_ovf_q   <= s2_ovf_d;
         last_q     <= last_d;
      end
   end

   assign out_valid = s2_v_q;
   assign out_fixed = s2_fixed_q;
   assign out_id    = s2_id_q;
   assign out_ovf   = s2_ovf_q;

endmodule

// File: tb/tb_f2x_arbiter.sv
// tb_f2x_arbiter: directed bench with a result scoreboard
// for the f2x_arbiter front end.
module tb_f2x_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [63:0] req_float;
   logic [1:0]  req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_fixed;
   logic        out_id;
   logic        out_ovf;

   logic [25:0] sbq[$];
   logic [25:0] last_out;
   logic [25:0] held;
   logic [25:0] bexp;
   int          checks = 0;
   int          errors = 0;
   int          nout = 0;
   int          nacc;
   int          n0;
   int          n;

   logic [31:0] bin [6];
   logic [23:0] bfx [6];
   logic        bov [6];

   f2x_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_float (req_float),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fixed (out_fixed),
      .out_id    (out_id),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   function automatic logic [25:0] model(input logic [31:0] f, input logic id);
      int unsigned e;
      int unsigned v;
      logic [23:0] fx;
      e = 32'(f[30:23]);
      if (f[30:0] == 31'd0) return {24'd0, id, 1'b0};
      if (e > 127) return {24'h7FFFFF, id, 1'b1};
      v = 32'h0080_0000 | 32'(f[22:0]);
      if (128 - e > 31) v = 0;
      else v = v >> (128 - e);
      fx = v[23:0];
      return {fx, id, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      #1;
      if (!reset) begin
         for (int i = 0; i < 2; i++)
            if (req_valid[i] && req_ready[i])
               sbq.push_back(model(req_float[i*32 +: 32], i[0]));
         if (out_valid && out_ready) begin
            nout++;
            last_out = {out_fixed, out_id, out_ovf};
            if (sbq.size() == 0)
               check("sb_underflow", 32'(sbq.size() > 0), 32'd1);
            else
               check("out", 32'(last_out), 32'(sbq.pop_front()));
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc();
      sample();
      step();
   endtask

   task automatic drain(input int maxc);
      int k;
      k = 0;
      while ((sbq.size() != 0 || out_valid) && k < maxc) begin
         cyc();
         k++;
      end
      check("drain_empty", 32'(sbq.size()), 32'd0);
   endtask

   task automatic wait_out(input string tag);
      int k;
      k = 0;
      while (!out_valid && k < 6) begin
         cyc();
         k++;
      end
      check(tag, 32'(out_valid), 32'd1);
   endtask

   initial begin
      bin[0] = 32'h00000000; bfx[0] = 24'h000000; bov[0] = 1'b0;
      bin[1] = 32'h80000000; bfx[1] = 24'h000000; bov[1] = 1'b0;
      bin[2] = 32'h40000000; bfx[2] = 24'h7FFFFF; bov[2] = 1'b1;
      bin[3] = 32'h7F800000; bfx[3] = 24'h7FFFFF; bov[3] = 1'b1;
      bin[4] = 32'h33000000; bfx[4] = 24'h000000; bov[4] = 1'b0;
      bin[5] = 32'h3FC90FDB; bfx[5] = 24'h6487ED; bov[5] = 1'b0;

      reset     = 1'b1;
      req_valid = 2'b11;
      req_float = '0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_fixed", 32'(out_fixed), 32'd0);
      check("rst_id", 32'(out_id), 32'd0);
      check("rst_ovf", 32'(out_ovf), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      reset     = 1'b0;
      req_valid = 2'b00;

      // round robin from reset
      req_float = {32'h3F000000, 32'h3F800000};
      req_valid = 2'b11;
      for (int i = 0; i < 6; i++) begin
         sample();
         check("rr_grant", 32'(req_ready), (i % 2) ? 32'd2 : 32'd1);
         if (i >= 2) check("rr_tput", 32'(out_valid), 32'd1);
         step();
      end
      req_valid = 2'b00;
      drain(10);

      // single requests and latency
      req_float = {32'h0, 32'h3F800000};
      req_valid = 2'b01;
      sample();
      check("single0_acc", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      sample();
      check("single0_lat1", 32'(out_valid), 32'd0);
      step();
      sample();
      check("single0_lat2", 32'(out_valid), 32'd1);
      check("single0_val", 32'(last_out), 32'({24'h400000, 1'b0, 1'b0}));
      step();
      req_float = {32'h3F000000, 32'h0};
      req_valid = 2'b10;
      cyc();
      req_valid = 2'b00;
      wait_out("single1_seen");
      sample();
      check("single1_val", 32'(last_out), 32'({24'h200000, 1'b1, 1'b0}));
      step();

      // boundary values, alternating requester
      for (int k = 0; k < 6; k++) begin
         req_float = {bin[k], bin[k]};
         req_valid = (k % 2) ? 2'b10 : 2'b01;
         cyc();
         req_valid = 2'b00;
         wait_out("bnd_seen");
         sample();
         bexp = {bfx[k], k[0], bov[k]};
         check("bnd_val", 32'(last_out), 32'(bexp));
         step();
      end
      drain(5);

      // backpressure with requester 0 streaming
      out_ready = 1'b0;
      req_valid = 2'b01;
      nacc = 0;
      held = '0;
      n0 = nout;
      for (int i = 0; i < 5; i++) begin
         req_float = {32'h0, 32'h3F800000 | (32'(nacc) << 20)};
         sample();
         if (req_ready[0]) nacc++;
         if (i >= 2) begin
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            if (i == 2) held = {out_fixed, out_id, out_ovf};
            else check("bp_hold", 32'({out_fixed, out_id, out_ovf}), 32'(held));
         end
         step();
      end
      check("bp_accepted", 32'(nacc), 32'd2);
      req_valid = 2'b00;
      out_ready = 1'b1;
      drain(10);
      check("bp_count", 32'(nout - n0), 32'd2);

      // reset with both stages full
      out_ready = 1'b0;
      req_float = {32'h0, 32'h3F000000};
      req_valid = 2'b01;
      cyc();
      cyc();
      req_valid = 2'b11;
      #1;
      check("mid_full", 32'(out_valid), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      sbq.delete();
      step();
      reset = 1'b0;
      req_float = {32'h3F800000, 32'h3FC90FDB};
      out_ready = 1'b1;
      n0 = nout;
      sample();
      check("mid_grant", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      wait_out("mid_seen");
      sample();
      check("mid_first", 32'(last_out), 32'({24'h6487ED, 1'b0, 1'b0}));
      check("mid_first_cnt", 32'(nout - n0), 32'd1);
      step();
      drain(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
